mr1_bus_arbiter: RTL and testbench

Shares one split-transaction memory port between the MR1 instruction bus (iBus) and data bus (dBus). The block sits between the MR1 core and the single memory/interconnect port. It arbitrates command requests, with dBus priority and a starvation guard for iBus. It records the source of every read in an in-order pending queue and routes each memory response back to the requester that issued it.

---
 rtl/mr1_bus_pkg.sv | 23 ++
 rtl/mr1_src_fifo.sv | 55 +++++
 rtl/mr1_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mr1_bus_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mr1_bus_pkg.sv
// Shared types and constants for the MR1 iBus/dBus shared-memory-port arbiter.
package mr1_bus_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  typedef struct packed {
    logic                  wr;
    logic [MEM_ADDR_W-1:0] address;
    logic [MEM_DATA_W-1:0] data;
    logic [1:0]            size;
  } memCmd_t;

endpackage

// File: rtl/mr1_src_fifo.sv
// In-order tag FIFO recording which bus issued each outstanding read.
module mr1_src_fifo
  import mr1_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  src_t                   pushTag,
  input  logic                   pop,
  output src_t                   popTag,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  src_t             tags [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign doPush = push && (!full || doPop);
  assign popTag = tags[rdPtr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      if (doPush && !doPop) begin
        count <= count + CNT_W'(1);
      end else if (doPop && !doPush) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Tag storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (doPush) tags[wrPtr] <= pushTag;
  end

endmodule

// File: rtl/mr1_bus_arbiter.sv
// Shares one split-transaction memory port between the MR1 iBus and dBus,
// with dBus priority, an iBus starvation guard and in-order response routing.
module mr1_bus_arbiter
  import mr1_bus_pkg::*;
#(
  parameter int unsigned MAX_PENDING  = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,

  input  logic                         iBus_cmd_valid,
  output logic                         iBus_cmd_ready,
  input  logic [MEM_ADDR_W-1:0]        iBus_cmd_payload_pc,
  output logic                         iBus_rsp_ready,
  output logic [MEM_DATA_W-1:0]        iBus_rsp_inst,
  output logic                         iBus_rsp_error,

  input  logic                         dBus_cmd_valid,
  output logic                         dBus_cmd_ready,
  input  logic                         dBus_cmd_payload_wr,
  input  logic [MEM_ADDR_W-1:0]        dBus_cmd_payload_address,
  input  logic [MEM_DATA_W-1:0]        dBus_cmd_payload_data,
  input  logic [1:0]                   dBus_cmd_payload_size,
  output logic                         dBus_rsp_ready,
  output logic [MEM_DATA_W-1:0]        dBus_rsp_data,
  output logic                         dBus_rsp_error,

  output logic                         mem_cmd_valid,
  input  logic                         mem_cmd_ready,
  output logic                         mem_cmd_wr,
  output logic [MEM_ADDR_W-1:0]        mem_cmd_address,
  output logic [MEM_DATA_W-1:0]        mem_cmd_data,
  output logic [1:0]                   mem_cmd_size,
  input  logic                         mem_rsp_valid,
  input  logic [MEM_DATA_W-1:0]        mem_rsp_data,
  input  logic                         mem_rsp_error,

  output logic [$clog2(MAX_PENDING):0] pending_count,
  output logic                         err_unexpected_rsp
);

  localparam int unsigned CNT_W    = $clog2(MAX_PENDING) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arbState_t;

  arbState_t           state;
  arbState_t           nextState;
  src_t                lockSrc;
  src_t                nextLockSrc;
  logic [STARVE_W-1:0] starveCnt;
  logic [STARVE_W-1:0] nextStarveCnt;
  logic                errUnexpected;

  src_t                grantSrc;
  src_t                popTag;
  logic                grantValid;
  logic                cmdValid;
  logic                cmdAccept;
  logic                pushRead;
  logic                rspPop;
  logic                slotFree;
  logic                iElig;
  logic                dElig;
  logic                starveHit;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [CNT_W-1:0]    fifoCount;

  memCmd_t             iCmd;
  memCmd_t             dCmd;
  memCmd_t             grantCmd;

  // A response popping this cycle frees a slot for a read issued in the same cycle.
  assign rspPop    = mem_rsp_valid && !fifoEmpty;
  assign slotFree  = !fifoFull || rspPop;
  assign iElig     = iBus_cmd_valid && slotFree;
  assign dElig     = dBus_cmd_valid && (dBus_cmd_payload_wr || slotFree);
  assign starveHit = (starveCnt == STARVE_W'(STARVE_LIMIT));

  assign iCmd = '{wr: 1'b0, address: iBus_cmd_payload_pc, data: '0, size: SIZE_W};
  assign dCmd = '{wr: dBus_cmd_payload_wr, address: dBus_cmd_payload_address,
                  data: dBus_cmd_payload_data, size: dBus_cmd_payload_size};

  // Arbiter state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= UNLOCKED;
      lockSrc   <= SRC_I;
      starveCnt <= '0;
    end else begin
      state     <= nextState;
      lockSrc   <= nextLockSrc;
      starveCnt <= nextStarveCnt;
    end
  end

  // Grant selection, lock tracking and starvation counting
  always_comb begin
    nextState     = state;
    nextLockSrc   = lockSrc;
    nextStarveCnt = starveCnt;
    grantValid    = 1'b0;
    grantSrc      = SRC_D;
    cmdValid      = 1'b0;
    cmdAccept     = 1'b0;
    pushRead      = 1'b0;

    if (state == LOCKED) begin
      grantValid = 1'b1;
      grantSrc   = lockSrc;
    end else begin
      if (dElig && !(iElig && starveHit)) begin
        grantValid = 1'b1;
        grantSrc   = SRC_D;
        if (iElig && !starveHit) nextStarveCnt = starveCnt + STARVE_W'(1);
      end else if (iElig) begin
        grantValid = 1'b1;
        grantSrc   = SRC_I;
      end
    end

    cmdValid  = reset_n && grantValid &&
                ((grantSrc == SRC_I) ? iBus_cmd_valid : dBus_cmd_valid);
    cmdAccept = cmdValid && mem_cmd_ready;
    pushRead  = cmdAccept && ((grantSrc == SRC_I) || !dBus_cmd_payload_wr);

    if (cmdValid && !mem_cmd_ready) begin
      nextState   = LOCKED;
      nextLockSrc = grantSrc;
    end else begin
      nextState   = UNLOCKED;
    end

    if (cmdAccept && (grantSrc == SRC_I)) nextStarveCnt = '0;
  end

  assign grantCmd        = (grantSrc == SRC_I) ? iCmd : dCmd;
  assign mem_cmd_valid   = cmdValid;
  assign mem_cmd_wr      = grantCmd.wr;
  assign mem_cmd_address = grantCmd.address;
  assign mem_cmd_data    = grantCmd.data;
  assign mem_cmd_size    = grantCmd.size;

  assign iBus_cmd_ready = reset_n && grantValid && (grantSrc == SRC_I) && mem_cmd_ready;
  assign dBus_cmd_ready = reset_n && grantValid && (grantSrc == SRC_D) && mem_cmd_ready;

  // Responses return in issue order; data lines are shared, strobes are steered.
  assign iBus_rsp_ready = reset_n && rspPop && (popTag == SRC_I);
  assign dBus_rsp_ready = reset_n && rspPop && (popTag == SRC_D);
  assign iBus_rsp_inst  = mem_rsp_data;
  assign iBus_rsp_error = mem_rsp_error;
  assign dBus_rsp_data  = mem_rsp_data;
  assign dBus_rsp_error = mem_rsp_error;

  // Sticky flag for a response with nothing outstanding
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      errUnexpected <= 1'b0;
    end else if (mem_rsp_valid && fifoEmpty) begin
      errUnexpected <= 1'b1;
    end
  end

  assign err_unexpected_rsp = errUnexpected;
  assign pending_count      = fifoCount;

  mr1_src_fifo #(
    .DEPTH(MAX_PENDING)
  ) u_srcFifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (pushRead),
    .pushTag(grantSrc),
    .pop    (rspPop),
    .popTag (popTag),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

endmodule

// File: tb/tb_mr1_bus_arbiter.sv
// Self-checking bench for mr1_bus_arbiter: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_mr1_bus_arbiter;

  localparam int unsigned MAX_PENDING  = 4;
  localparam int unsigned STARVE_LIMIT = 3;
  localparam logic [31:0] PC_T = 32'h1111_0000;
  localparam logic [31:0] DA_T = 32'h2222_0040;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iv, dv, dwr, mcr, rv, rerr;
  logic [31:0] ipc, daddr, ddata, rdat;
  logic [1:0]  dsize;

  logic        iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_error;
  logic [31:0] iBus_rsp_inst;
  logic        dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error;
  logic [31:0] dBus_rsp_data;
  logic        mem_cmd_valid, mem_cmd_wr;
  logic [31:0] mem_cmd_address, mem_cmd_data;
  logic [1:0]  mem_cmd_size;
  logic [2:0]  pending_count;
  logic        err_unexpected_rsp;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic        rstN, iv, dv, dwr, mcr;
    logic        expMv, expWr, expIr, expDr;
    logic [31:0] expAddr;
    logic [1:0]  expSize;
  } vec_t;
  vec_t vecs [8];

  // reference model state (tags: 1 = iBus, 2 = dBus)
  int   qTags[$];
  int   starve, lockSrc, win;
  bit   locked, errM, iHold, dHold, slotFree, iE, dE, acc;
  logic expI;

  always #5 clk = ~clk;

  mr1_bus_arbiter #(
    .MAX_PENDING (MAX_PENDING),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .iBus_cmd_valid          (iv),
    .iBus_cmd_ready          (iBus_cmd_ready),
    .iBus_cmd_payload_pc     (ipc),
    .iBus_rsp_ready          (iBus_rsp_ready),
    .iBus_rsp_inst           (iBus_rsp_inst),
    .iBus_rsp_error          (iBus_rsp_error),
    .dBus_cmd_valid          (dv),
    .dBus_cmd_ready          (dBus_cmd_ready),
    .dBus_cmd_payload_wr     (dwr),
    .dBus_cmd_payload_address(daddr),
    .dBus_cmd_payload_data   (ddata),
    .dBus_cmd_payload_size   (dsize),
    .dBus_rsp_ready          (dBus_rsp_ready),
    .dBus_rsp_data           (dBus_rsp_data),
    .dBus_rsp_error          (dBus_rsp_error),
    .mem_cmd_valid           (mem_cmd_valid),
    .mem_cmd_ready           (mcr),
    .mem_cmd_wr              (mem_cmd_wr),
    .mem_cmd_address         (mem_cmd_address),
    .mem_cmd_data            (mem_cmd_data),
    .mem_cmd_size            (mem_cmd_size),
    .mem_rsp_valid           (rv),
    .mem_rsp_data            (rdat),
    .mem_rsp_error           (rerr),
    .pending_count           (pending_count),
    .err_unexpected_rsp      (err_unexpected_rsp)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    iv = 1'b0; dv = 1'b0; dwr = 1'b0; mcr = 1'b0; rv = 1'b0; rerr = 1'b0;
    ipc = '0; daddr = '0; ddata = '0; rdat = '0; dsize = 2'd0;
  endtask

  task automatic doReset();
    idleInputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, PC_T,  2'd2};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, DA_T,  2'd1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, DA_T,  2'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, DA_T,  2'd1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DA_T,  2'd1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, PC_T,  2'd2};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0};

    // reset state
    doReset();
    #1;
    chk1 ("rst_mem_valid", mem_cmd_valid, 1'b0);
    chk32("rst_pending", 32'(pending_count), 32'd0);
    chk1 ("rst_err", err_unexpected_rsp, 1'b0);
    chk1 ("rst_i_rsp", iBus_rsp_ready, 1'b0);

    // combinational grant table from the idle state; valids drop before each edge
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      reset_n = vecs[v].rstN; iv = vecs[v].iv; dv = vecs[v].dv;
      dwr = vecs[v].dwr; mcr = vecs[v].mcr;
      ipc = PC_T; daddr = DA_T; ddata = 32'h5a5a_0000; dsize = 2'd1;
      #1;
      chk1("vec_mem_valid", mem_cmd_valid, vecs[v].expMv);
      chk1("vec_i_ready", iBus_cmd_ready, vecs[v].expIr);
      chk1("vec_d_ready", dBus_cmd_ready, vecs[v].expDr);
      if (vecs[v].expMv) begin
        chk1 ("vec_wr", mem_cmd_wr, vecs[v].expWr);
        chk32("vec_addr", mem_cmd_address, vecs[v].expAddr);
        chk32("vec_size", 32'(mem_cmd_size), 32'(vecs[v].expSize));
      end
      iv = 1'b0; dv = 1'b0; reset_n = 1'b1;
    end

    // starvation guard: D,D,D,I,D,D,D,I with one response per cycle
    doReset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      iv = 1'b1; dv = 1'b1; dwr = 1'b0; mcr = 1'b1;
      ipc = 32'h1000 + 32'(k * 4); daddr = 32'h2000 + 32'(k * 4);
      rv = (k > 0); rdat = 32'(k);
      #1;
      expI = (k == 3 || k == 7);
      chk1 ("seq_i_ready", iBus_cmd_ready, expI);
      chk1 ("seq_d_ready", dBus_cmd_ready, !expI);
      chk32("seq_addr", mem_cmd_address, expI ? ipc : daddr);
      if (k > 0) begin
        chk1("seq_i_rsp", iBus_rsp_ready, k == 4);
        chk1("seq_d_rsp", dBus_rsp_ready, k != 4);
      end
    end
    // no responses: three more loads fill the queue, then both stall
    for (int k = 8; k < 12; k++) begin
      @(negedge clk);
      rv = 1'b0;
      ipc = 32'h1000 + 32'(k * 4); daddr = 32'h2000 + 32'(k * 4);
      #1;
      chk1("fill_d_ready", dBus_cmd_ready, k < 11);
      chk1("fill_i_ready", iBus_cmd_ready, 1'b0);
      if (k == 11) begin
        chk1 ("full_mem_valid", mem_cmd_valid, 1'b0);
        chk32("full_pending", 32'(pending_count), 32'd4);
      end
    end
    // store bypasses the stalled fetch
    @(negedge clk);
    ipc = 32'h3000; dwr = 1'b1; daddr = 32'h80; ddata = 32'hDEAD; dsize = 2'd2;
    #1;
    chk1 ("byp_mem_valid", mem_cmd_valid, 1'b1);
    chk1 ("byp_wr", mem_cmd_wr, 1'b1);
    chk32("byp_addr", mem_cmd_address, 32'h80);
    chk32("byp_data", mem_cmd_data, 32'hDEAD);
    chk1 ("byp_d_ready", dBus_cmd_ready, 1'b1);
    chk1 ("byp_i_ready", iBus_cmd_ready, 1'b0);
    // response pop lets the held fetch through in the same cycle
    @(negedge clk);
    dv = 1'b0; dwr = 1'b0; rv = 1'b1; rdat = 32'h55;
    #1;
    chk32("pp_pending_before", 32'(pending_count), 32'd4);
    chk1 ("pp_i_ready", iBus_cmd_ready, 1'b1);
    chk32("pp_addr", mem_cmd_address, 32'h3000);
    chk1 ("pp_i_rsp", iBus_rsp_ready, 1'b1);
    chk32("pp_i_inst", iBus_rsp_inst, 32'h55);
    chk1 ("pp_d_rsp", dBus_rsp_ready, 1'b0);
    @(negedge clk);
    iv = 1'b0; rv = 1'b0;
    #1;
    chk32("pp_pending_after", 32'(pending_count), 32'd4);
    // drain: D,D,D,I
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      rv = 1'b1; rdat = 32'hB0 + 32'(n);
      #1;
      chk1("drain_d_rsp", dBus_rsp_ready, n < 3);
      chk1("drain_i_rsp", iBus_rsp_ready, n == 3);
      chk32("drain_data", dBus_rsp_data, 32'hB0 + 32'(n));
    end
    // response with nothing outstanding
    @(negedge clk);
    rv = 1'b1; rdat = 32'h99;
    #1;
    chk32("unx_pending", 32'(pending_count), 32'd0);
    chk1 ("unx_i_rsp", iBus_rsp_ready, 1'b0);
    chk1 ("unx_d_rsp", dBus_rsp_ready, 1'b0);
    chk1 ("unx_err_before", err_unexpected_rsp, 1'b0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      rv = 1'b0;
      #1;
      chk1("unx_err_sticky", err_unexpected_rsp, 1'b1);
    end

    // lock: iBus stalled three cycles, dBus arrives mid-stall
    doReset();
    #1;
    chk1("lock_err_cleared", err_unexpected_rsp, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      iv = 1'b1; ipc = (c == 4) ? 32'h104 : 32'h100;
      dv = (c >= 2); dwr = 1'b0; daddr = 32'h200;
      mcr = (c >= 3);
      #1;
      chk1 ("lock_mem_valid", mem_cmd_valid, 1'b1);
      chk32("lock_addr", mem_cmd_address, (c == 4) ? 32'h200 : 32'h100);
      chk1 ("lock_i_ready", iBus_cmd_ready, c == 3);
      chk1 ("lock_d_ready", dBus_cmd_ready, c == 4);
    end

    // asynchronous reset with two reads pending
    @(negedge clk);
    dv = 1'b0; iv = 1'b1; ipc = 32'h300; mcr = 1'b1;
    #1;
    chk32("mid_pending", 32'(pending_count), 32'd2);
    chk1 ("mid_mem_valid", mem_cmd_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk32("mid_rst_pending", 32'(pending_count), 32'd0);
    chk1 ("mid_rst_mem_valid", mem_cmd_valid, 1'b0);
    chk1 ("mid_rst_i_ready", iBus_cmd_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1; dv = 1'b1; dwr = 1'b0; daddr = 32'h400;
    #1;
    chk1 ("post_rst_d_ready", dBus_cmd_ready, 1'b1);
    chk1 ("post_rst_i_ready", iBus_cmd_ready, 1'b0);
    chk32("post_rst_addr", mem_cmd_address, 32'h400);

    // response ordering I, D, I
    doReset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idleInputs();
      mcr = 1'b1;
      case (c)
        0: begin iv = 1'b1; ipc = 32'h0; end
        1: begin dv = 1'b1; daddr = 32'h40; end
        2: begin iv = 1'b1; ipc = 32'h4; end
        default: begin rv = 1'b1; rdat = 32'hA + 32'(c - 3); end
      endcase
      #1;
      if (c < 3) begin
        chk1("ord_cmd_ready", iBus_cmd_ready | dBus_cmd_ready, 1'b1);
      end else begin
        chk1 ("ord_i_rsp", iBus_rsp_ready, c != 4);
        chk1 ("ord_d_rsp", dBus_rsp_ready, c == 4);
        chk32("ord_data", (c == 4) ? dBus_rsp_data : iBus_rsp_inst, 32'hA + 32'(c - 3));
      end
    end

    // randomized run against the reference model
    doReset();
    qTags.delete();
    starve = 0; locked = 1'b0; lockSrc = 0; errM = 1'b0; iHold = 1'b0; dHold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!iHold) begin
        iv = ($urandom_range(0, 99) < 60); ipc = $urandom;
      end
      if (!dHold) begin
        dv = ($urandom_range(0, 99) < 60); dwr = ($urandom_range(0, 2) == 0);
        daddr = $urandom; ddata = $urandom; dsize = 2'($urandom_range(0, 2));
      end
      mcr  = ($urandom_range(0, 99) < 70);
      rv   = (qTags.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 2);
      rdat = $urandom; rerr = 1'($urandom_range(0, 1));
      #1;
      slotFree = (qTags.size() < MAX_PENDING) || (rv && qTags.size() > 0);
      iE = iv && slotFree;
      dE = dv && (dwr || slotFree);
      if (locked)          win = lockSrc;
      else if (iE && dE)   win = (starve == STARVE_LIMIT) ? 1 : 2;
      else if (iE)         win = 1;
      else if (dE)         win = 2;
      else                 win = 0;

      chk1("rnd_mem_valid", mem_cmd_valid, win != 0);
      chk1("rnd_i_ready", iBus_cmd_ready, win == 1 && mcr);
      chk1("rnd_d_ready", dBus_cmd_ready, win == 2 && mcr);
      if (win == 1) begin
        chk32("rnd_i_addr", mem_cmd_address, ipc);
        chk1 ("rnd_i_wr", mem_cmd_wr, 1'b0);
        chk32("rnd_i_size", 32'(mem_cmd_size), 32'd2);
      end else if (win == 2) begin
        chk32("rnd_d_addr", mem_cmd_address, daddr);
        chk1 ("rnd_d_wr", mem_cmd_wr, dwr);
        chk32("rnd_d_data", mem_cmd_data, ddata);
        chk32("rnd_d_size", 32'(mem_cmd_size), 32'(dsize));
      end
      chk1 ("rnd_i_rsp", iBus_rsp_ready, rv && qTags.size() > 0 && qTags[0] == 1);
      chk1 ("rnd_d_rsp", dBus_rsp_ready, rv && qTags.size() > 0 && qTags[0] == 2);
      chk32("rnd_rsp_data", dBus_rsp_data, rdat);
      chk32("rnd_rsp_inst", iBus_rsp_inst, rdat);
      chk1 ("rnd_rsp_err", iBus_rsp_error, rerr);
      chk32("rnd_pending", 32'(pending_count), 32'(qTags.size()));
      chk1 ("rnd_err", err_unexpected_rsp, errM);

      acc = (win != 0) && mcr;
      if (acc && win == 1) starve = 0;
      else if (!locked && iE && dE && win == 2 && starve < STARVE_LIMIT) starve++;
      locked  = (win != 0) && !mcr;
      lockSrc = win;
      if (rv) begin
        if (qTags.size() > 0) void'(qTags.pop_front());
        else errM = 1'b1;
      end
      if (acc && (win == 1 || !dwr)) qTags.push_back(win);
      iHold = iv && !(acc && win == 1);
      dHold = dv && !(acc && win == 2);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
